effect_chain_seq: RTL and testbench
===================================

# effect_chain_seq

Sequencer that carries each audio sample through a chain of NUM_STAGES effect stages (gate, distortion, delay, …) in order. Each stage uses the single-cycle valid-strobe interface of the effect blocks. The block sits between the codec sample source and the DAC player. It issues one strobe per stage, waits for that stage's completion strobe, and forwards the result to the next stage. It also skips disabled stages, bypasses hung stages on a watchdog timeout, and flags dropped samples.

## Interface
- NUM_STAGES, 4: number of effect stages in the chain (1–8).
- TIMEOUT, 255: watchdog limit in cycles spent waiting on one stage (1–65535).
- i_clk  in  1: clock.
- i_rst  in  1: reset. Synchronous, active-high.
- i_valid  in  1: new-sample strobe.
- i_data  in  16: signed input sample.
- i_stage_en  in  NUM_STAGES: per-stage run mask. Sampled when that stage is reached.
- o_fx_valid  out  NUM_STAGES: one-hot strobe to stage k.
- o_fx_data  out  16: shared data bus to all stages. Only meaningful when a strobe is high.
- i_fx_valid  in  NUM_STAGES: completion strobe from stage k.
- i_fx_data  in  16*NUM_STAGES: stage results, packed. Stage k occupies bits [16k+15:16k].
- o_valid  out  1: chain-output strobe, high for 1 cycle.
- o_data  out  16: signed chain output. Held between strobes.
- o_busy  out  1: high in every state except IDLE.
- o_overrun  out  1: sticky; a sample was dropped.
- o_timeout  out  NUM_STAGES: sticky per-stage watchdog flags.
- i_clear  in  1: clears o_overrun and o_timeout.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. An internal stage index k counts 0..NUM_STAGES-1. A working register holds the current sample.
- IDLE:
  - i_valid captures i_data into the working register, sets k=0, and moves to ISSUE.
- ISSUE:
  - If i_stage_en[k]=1: assert o_fx_valid[k] for this cycle only, drive o_fx_data with the working register, clear the watchdog counter, and go to WAIT.
  - If i_stage_en[k]=0: no strobe; the working register is unchanged. If k=NUM_STAGES-1, go to DONE; otherwise k++ and stay in ISSUE.
- WAIT:
  - Only i_fx_valid[k] is honoured. Strobes from other stages are ignored.
  - On i_fx_valid[k]: load i_fx_data[k] into the working register. Then go to DONE if k=NUM_STAGES-1; otherwise k++ and go to ISSUE.
  - Watchdog: the counter increments on every WAIT cycle without a response. When it reaches TIMEOUT, set o_timeout[k] and keep the working register unchanged (the stage is bypassed). Then advance exactly as for a response.
  - If a response and the timeout occur in the same cycle, the response wins and no flag is set.
- DONE:
  - Assert o_valid for one cycle with o_data equal to the working register, then go to IDLE.
- Overrun:
  - i_valid in any state other than IDLE drops that sample and sets o_overrun. The sample in flight is unaffected.
- Sticky flags:
  - i_clear zeroes the flags.
  - If i_clear and a set event occur in the same cycle, the set wins.
- Data path: pure move, no arithmetic. Widths are 16 bits throughout. The watchdog counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

## Timing
- Reset values: o_fx_valid=0, o_fx_data=0, o_valid=0, o_data=0, o_busy=0, o_overrun=0, o_timeout=0. State=IDLE, k=0.
- Reset mid-chain: the next cycle is IDLE with all outputs at reset values. No strobe or o_valid is emitted for the aborted sample.
- All outputs are registered.
- Stages must respond at least 1 cycle after their strobe. A response in the same cycle as the strobe is ignored.
- Timing with i_valid in cycle 0, N stages enabled, each with latency L_k:
  - Stage k's strobe is issued in ISSUE and its response is taken in WAIT.
  - Each enabled stage costs 1+L_k cycles. Each disabled stage costs 1 cycle.
  - o_valid is high in cycle 1 + Σ(1+L_k) + (count of disabled stages).
  - Example: four enabled 1-cycle stages put o_valid in cycle 9.
  - Example: all stages disabled puts o_valid in cycle NUM_STAGES+1, with o_data=i_data.
- A timed-out stage costs 1+TIMEOUT cycles.
- Minimum sample period without overrun equals the chain latency plus 1 cycle (the DONE cycle).

## Configuration
- EFFECT_SEQ_TIMEOUT_EN defined: the watchdog counter and o_timeout logic are present, as described above.
- EFFECT_SEQ_TIMEOUT_EN undefined:
  - No counter is built, and WAIT waits indefinitely for i_fx_valid[k].
  - o_timeout is tied to 0 and TIMEOUT is ignored.
  - i_clear affects only o_overrun.

## Test plan
- Four enabled stages, each modelled as "+1, 1-cycle latency"; i_valid with i_data=100 -> four one-hot strobes in cycles 1,3,5,7 carrying 100,101,102,103; o_valid in cycle 9 with o_data=104.
- i_stage_en=4'b0000, i_data=-5 -> no o_fx_valid pulses; o_valid in cycle 5 with o_data=-5.
- Stage 2 never responds, TIMEOUT=10, stages add 1, i_data=0 -> o_timeout=4'b0100; o_data=3; the chain completes. With the macro undefined, the chain hangs and o_busy stays 1.
- Second i_valid in cycle 4 of a busy chain -> o_overrun=1; the first sample completes unchanged; only one o_valid is produced. Then i_clear and a fresh overrun in the same cycle -> o_overrun stays 1.
- Stray i_fx_valid[3] while waiting on stage 1 -> ignored; the result is unchanged.
- i_rst asserted in cycle 4 -> next cycle all outputs are 0 and state is IDLE; a new i_valid then runs a normal chain.

Source files
------------

// File: rtl/effect_chain_seq.sv
// Effect-chain sequencer: walks one sample through NUM_STAGES effect blocks via valid strobes.
// Optional watchdog/bypass for hung stages is built when EFFECT_SEQ_TIMEOUT_EN is defined.
module effect_chain_seq #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [15:0]              i_data,
  input  logic [NUM_STAGES-1:0]    i_stage_en,
  output logic [NUM_STAGES-1:0]    o_fx_valid,
  output logic [15:0]              o_fx_data,
  input  logic [NUM_STAGES-1:0]    i_fx_valid,
  input  logic [16*NUM_STAGES-1:0] i_fx_data,
  output logic                     o_valid,
  output logic [15:0]              o_data,
  output logic                     o_busy,
  output logic                     o_overrun,
  output logic [NUM_STAGES-1:0]    o_timeout,
  input  logic                     i_clear
);

  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [KW-1:0]         K_ONE  = KW'(1);
  localparam logic [KW-1:0]         K_LAST = KW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] S_ONE  = NUM_STAGES'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("effect_chain_seq: NUM_STAGES out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("effect_chain_seq: TIMEOUT out of range");
  end

  logic [1:0]      r_state;
  logic [KW-1:0]   r_k;
  logic [15:0]     r_work;
  logic            r_en_cur;
  logic [1:0]      w_state_nxt;
  logic [KW-1:0]   w_k_nxt;
  logic [15:0]     w_work_nxt;
  logic            w_advance;
  logic            w_ovr_set;
  logic [15:0]     w_resp_dat;

  assign w_resp_dat = i_fx_data[{r_k, 4'b0000} +: 16];
  assign w_ovr_set  = i_valid && (r_state != S_IDLE);

`ifdef EFFECT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [CW-1:0]         w_cnt_inc;
  logic [NUM_STAGES-1:0] w_to_set;

  assign w_cnt_inc = (r_cnt == TO_VAL) ? r_cnt : r_cnt + C_ONE;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_work_nxt  = r_work;
    w_advance   = 1'b0;
`ifdef EFFECT_SEQ_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_to_set    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_work_nxt  = i_data;
          w_k_nxt     = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_en_cur) begin
          w_state_nxt = S_WAIT;
`ifdef EFFECT_SEQ_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end else if (r_k == K_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt = r_k + K_ONE;
        end
      end
      S_WAIT: begin
        if (i_fx_valid[r_k]) begin
          w_work_nxt = w_resp_dat;
          w_advance  = 1'b1;
        end
`ifdef EFFECT_SEQ_TIMEOUT_EN
        else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == TO_VAL) begin
            w_to_set[r_k] = 1'b1;
            w_advance     = 1'b1;
          end
        end
`endif
        if (w_advance) begin
          if (r_k == K_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_k_nxt     = r_k + K_ONE;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state, so the strobe lands in the ISSUE cycle itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_work     <= '0;
      r_en_cur   <= 1'b0;
      o_fx_valid <= '0;
      o_fx_data  <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_work     <= w_work_nxt;
      r_en_cur   <= i_stage_en[w_k_nxt];
      o_busy     <= (w_state_nxt != S_IDLE);
      o_valid    <= (w_state_nxt == S_DONE);
      o_overrun  <= w_ovr_set | (o_overrun & ~i_clear);
      if (w_state_nxt == S_DONE) o_data <= w_work_nxt;
      if ((w_state_nxt == S_ISSUE) && i_stage_en[w_k_nxt]) begin
        o_fx_valid <= S_ONE << w_k_nxt;
        o_fx_data  <= w_work_nxt;
      end else begin
        o_fx_valid <= '0;
      end
    end
  end

`ifdef EFFECT_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      o_timeout <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      o_timeout <= w_to_set | (o_timeout & ~{NUM_STAGES{i_clear}});
    end
  end
`else
  assign o_timeout = '0;
`endif

endmodule

// File: tb/tb_effect_chain_seq.sv
// Directed bench for effect_chain_seq: four "+1" stage models with per-stage latency and mute control.
module tb_effect_chain_seq;
  localparam int NS = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_valid, i_clear;
  logic [15:0]   i_data;
  logic [NS-1:0] i_stage_en, i_fx_valid, o_fx_valid, o_timeout;
  logic [16*NS-1:0] i_fx_data;
  logic [15:0]   o_fx_data, o_data;
  logic          o_valid, o_busy, o_overrun;

  effect_chain_seq #(.NUM_STAGES(NS), .TIMEOUT(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_stage_en(i_stage_en), .o_fx_valid(o_fx_valid), .o_fx_data(o_fx_data),
    .i_fx_valid(i_fx_valid), .i_fx_data(i_fx_data), .o_valid(o_valid),
    .o_data(o_data), .o_busy(o_busy), .o_overrun(o_overrun),
    .o_timeout(o_timeout), .i_clear(i_clear)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;

  int          pend [NS];
  logic [15:0] hold [NS];
  int          lat  [NS];
  logic [NS-1:0] resp_en;
  int          ov_cyc, clr_cyc, rst_cyc, stray_cyc;
  int          str_cyc [8];
  logic [NS-1:0] str_vec [8];
  logic [15:0] str_dat [8];
  int          n_str, vcyc, extra;
  logic [15:0] vdat;
  logic        busy1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic defaults();
    i_stage_en = '1; resp_en = '1;
    for (int k = 0; k < NS; k++) lat[k] = 1;
    ov_cyc = -1; clr_cyc = -1; rst_cyc = -1; stray_cyc = -1;
  endtask

  // Stage model: each enabled stage answers with input+1 lat[k] cycles after its strobe.
  task automatic step_stages();
    i_fx_valid = '0;
    for (int k = 0; k < NS; k++) begin
      if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) begin
          i_fx_valid[k] = 1'b1;
          i_fx_data[16*k +: 16] = hold[k] + 16'd1;
        end
      end
    end
  endtask

  task automatic run_chain(input logic [15:0] d, input int max_cyc);
    for (int k = 0; k < NS; k++) pend[k] = 0;
    n_str = 0; vcyc = -1; vdat = '0; busy1 = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1; i_data = d; i_clear = 1'b0; i_rst = 1'b0; i_fx_valid = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge i_clk);
      i_valid = (c == ov_cyc);
      if (c == ov_cyc) i_data = 16'd999;
      i_clear = (c == clr_cyc);
      i_rst   = (c == rst_cyc);
      step_stages();
      if (c == stray_cyc) begin
        i_fx_valid[3] = 1'b1;
        i_fx_data[63:48] = 16'h7777;
      end
      if (c == 1) busy1 = o_busy;
      if (c == rst_cyc + 1) begin
        check("rst_fx_valid", o_fx_valid, 0);
        check("rst_fx_data", o_fx_data, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_busy", o_busy, 0);
      end
      if (o_fx_valid != '0) begin
        if (n_str < 8) begin
          str_cyc[n_str] = c; str_vec[n_str] = o_fx_valid; str_dat[n_str] = o_fx_data;
        end
        n_str++;
      end
      for (int k = 0; k < NS; k++)
        if (o_fx_valid[k] && resp_en[k]) begin
          pend[k] = lat[k];
          hold[k] = o_fx_data;
        end
      if (o_valid) begin
        vcyc = c; vdat = o_data;
        break;
      end
    end
    i_valid = 1'b0; i_clear = 1'b0; i_rst = 1'b0; i_fx_valid = '0;
  endtask

  task automatic idle(input int n);
    extra = 0;
    repeat (n) begin
      @(negedge i_clk);
      i_valid = 1'b0; i_clear = 1'b0; i_rst = 1'b0; i_fx_valid = '0;
      if (o_valid) extra++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_data = '0;
    i_fx_valid = '0; i_fx_data = '0;
    defaults();
    repeat (3) @(negedge i_clk);
    check("reset_fx_valid", o_fx_valid, 0);
    check("reset_valid", o_valid, 0);
    check("reset_data", o_data, 0);
    check("reset_busy", o_busy, 0);
    check("reset_overrun", o_overrun, 0);
    check("reset_timeout", o_timeout, 0);
    i_rst = 1'b0;
    idle(2);

    // Four enabled +1 stages, 1-cycle latency
    run_chain(16'd100, 40);
    check("t1_nstrobe", n_str, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_strobe_cyc", str_cyc[i], 1 + 2 * i);
      check("t1_strobe_vec", str_vec[i], 32'd1 << i);
      check("t1_strobe_dat", str_dat[i], 100 + i);
    end
    check("t1_valid_cyc", vcyc, 9);
    check("t1_data", vdat, 104);
    check("t1_busy_c1", busy1, 1);
    idle(1);
    check("t1_idle_busy", o_busy, 0);
    check("t1_idle_valid", o_valid, 0);

    // All stages disabled: pass-through
    i_stage_en = 4'b0000;
    run_chain(16'hFFFB, 40);
    check("t2_nstrobe", n_str, 0);
    check("t2_valid_cyc", vcyc, 5);
    check("t2_data", vdat, 16'hFFFB);
    defaults();
    idle(2);

    // Stage 2 never responds
    resp_en = 4'b1011;
    run_chain(16'd0, 40);
`ifdef EFFECT_SEQ_TIMEOUT_EN
    check("t3_valid_cyc", vcyc, 18);
    check("t3_data", vdat, 3);
    check("t3_timeout", o_timeout, 4'b0100);
    idle(1);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    check("t3_clear_timeout", o_timeout, 0);
`else
    check("t3_hang_valid", vcyc, -1);
    check("t3_hang_busy", o_busy, 1);
    check("t3_no_timeout", o_timeout, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("t3_rst_busy", o_busy, 0);
`endif
    defaults();
    idle(2);

    // Overrun: second sample in cycle 4 is dropped
    check("t4_pre_overrun", o_overrun, 0);
    ov_cyc = 4;
    run_chain(16'd200, 40);
    check("t4_valid_cyc", vcyc, 9);
    check("t4_data", vdat, 204);
    check("t4_overrun", o_overrun, 1);
    defaults();
    idle(12);
    check("t4_single_valid", extra, 0);
    // Clear and fresh overrun together: set wins
    ov_cyc = 2; clr_cyc = 2;
    run_chain(16'd300, 40);
    check("t4b_data", vdat, 304);
    check("t4b_overrun", o_overrun, 1);
    defaults();
    idle(1);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    check("t4b_clear", o_overrun, 0);
    idle(2);

    // Stray strobe from stage 3 while stage 1 (latency 3) is pending
    lat[1] = 3; stray_cyc = 4;
    run_chain(16'd50, 40);
    check("t5_valid_cyc", vcyc, 11);
    check("t5_stage2_in", str_dat[2], 52);
    check("t5_data", vdat, 54);
    defaults();
    idle(2);

    // Reset mid-chain, then a clean chain
    rst_cyc = 4;
    run_chain(16'd10, 10);
    check("t6_no_valid", vcyc, -1);
    defaults();
    idle(2);
    run_chain(16'd10, 40);
    check("t6_valid_cyc", vcyc, 9);
    check("t6_data", vdat, 14);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
